// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester, grant/return and RAM-side signals for the RAM port arbiter.
// The arbiter uses the slave view; requesters and the RAM model use the master view.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  // CPU requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_grant;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  // Auxiliary requester
  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_grant;
  logic              aux_rvalid;
  logic [DATA_W-1:0] aux_rdata;

  // Shared RAM port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_grant, cpu_rvalid, cpu_rdata,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_grant, aux_rvalid, aux_rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_grant, cpu_rvalid, cpu_rdata,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_grant, aux_rvalid, aux_rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read RAM port between a fixed-priority CPU and an
// auxiliary requester. A starvation counter force-grants aux after STARVE_MAX
// consecutive denied cycles. Read data returns one cycle after the grant.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_port_arbiter_if.slave    bus,
  output logic [1:0]           owner
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  logic [CntW-1:0]   starve_cnt, starve_cnt_d;
  logic              force_aux;
  // Raw winners feed state; gated grants are what the outside world sees.
  logic              cpu_win, aux_win;
  logic              cpu_gnt, aux_gnt;
  logic              cpu_pend, aux_pend;
  logic [DATA_W-1:0] cpu_hold, aux_hold;

  // Arbitration: CPU has priority unless aux has waited STARVE_MAX cycles.
  always_comb begin
    force_aux = bus.aux_req && (starve_cnt == StarveMax);
    aux_win   = bus.aux_req && (!bus.cpu_req || force_aux);
    cpu_win   = bus.cpu_req && !aux_win;
    // Grants are suppressed while reset is held low.
    aux_gnt   = reset && aux_win;
    cpu_gnt   = reset && cpu_win;
  end

  assign bus.cpu_grant = cpu_gnt;
  assign bus.aux_grant = aux_gnt;

  // RAM port mux: drive the granted requester's access, otherwise all zero.
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = {ADDR_W{1'b0}};
    bus.mem_din  = {DATA_W{1'b0}};
    if (cpu_gnt) begin
      bus.mem_we   = bus.cpu_we;
      bus.mem_addr = bus.cpu_addr;
      bus.mem_din  = bus.cpu_wdata;
    end else if (aux_gnt) begin
      bus.mem_we   = bus.aux_we;
      bus.mem_addr = bus.aux_addr;
      bus.mem_din  = bus.aux_wdata;
    end
  end

  // Starvation counter next state: count denied aux cycles, saturating.
  always_comb begin
    starve_cnt_d = '0;
    if (bus.aux_req && !aux_win) begin
      starve_cnt_d = (starve_cnt == StarveMax) ? starve_cnt : starve_cnt + 4'd1;
    end
  end

  // State registers: counter, last owner, read-return pipeline and hold data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      owner      <= 2'b00;
      cpu_pend   <= 1'b0;
      aux_pend   <= 1'b0;
      cpu_hold   <= {DATA_W{1'b0}};
      aux_hold   <= {DATA_W{1'b0}};
    end else begin
      starve_cnt <= starve_cnt_d;
      owner      <= {aux_win, cpu_win};
      cpu_pend   <= cpu_win && !bus.cpu_we;
      aux_pend   <= aux_win && !bus.aux_we;
      // Capture the returned word at the end of its valid cycle.
      if (cpu_pend) cpu_hold <= bus.mem_dout;
      if (aux_pend) aux_hold <= bus.mem_dout;
    end
  end

  // Read return: pass RAM data through during the valid cycle, else the held word.
  always_comb begin
    bus.cpu_rvalid = cpu_pend;
    bus.aux_rvalid = aux_pend;
    bus.cpu_rdata  = cpu_pend ? bus.mem_dout : cpu_hold;
    bus.aux_rdata  = aux_pend ? bus.mem_dout : aux_hold;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single external RAM port (write_en / addr / data_in / data_out) between the CPU (override-RAM build) and one auxiliary requester, e.g. a display or glyph fetch unit.
- CPU has fixed priority; a starvation counter guarantees the auxiliary requester a slot.
- One access per clock, with single-cycle grant.
- RAM is synchronous-read: read data returns one cycle after the granted address.

Parameters:
ADDR_W, 10, RAM address width
DATA_W, 16, RAM data width
STARVE_MAX, 4, consecutive denied aux cycles before aux is force-granted (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request; hold with cpu_we/addr/wdata stable until cpu_grant
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_grant  out  1  CPU access performed this cycle (combinational)
cpu_rvalid  out  1  CPU read data valid (registered)
cpu_rdata  out  DATA_W  CPU read data
aux_req, aux_we, aux_addr, aux_wdata  in  1/1/ADDR_W/DATA_W  auxiliary request; same rules as CPU
aux_grant  out  1  aux access performed this cycle
aux_rvalid  out  1  aux read data valid
aux_rdata  out  DATA_W  aux read data
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_din  out  DATA_W  RAM write data
mem_dout  in  DATA_W  RAM read data, valid the cycle after the address is presented
owner  out  2  registered last grant: 00 none, 01 cpu, 10 aux

Behaviour:
- Reset (reset=0, asynchronous):
  - starve_cnt=0, owner=00.
  - cpu_rvalid=aux_rvalid=0; cpu_rdata=aux_rdata=0.
  - Any in-flight read return is discarded; no rvalid appears after reset releases.
  - Grants are combinational, but are forced to 0 while reset=0.
- Arbitration each cycle (combinational from reqs and starve_cnt):
  - force_aux = aux_req && (starve_cnt == STARVE_MAX).
  - aux_grant = aux_req && (!cpu_req || force_aux).
  - cpu_grant = cpu_req && !aux_grant.
  - At most one grant is high per cycle.
- Memory mux:
  - On a grant, mem_we/mem_addr/mem_din follow the granted requester's we/addr/wdata.
  - With no grant: mem_we=0, mem_addr=0, mem_din=0.
  - mem_we is never high without a grant.
- Starvation counter:
  - At each edge, if aux_req && !aux_grant, starve_cnt increments, saturating at STARVE_MAX.
  - If aux_grant or !aux_req, starve_cnt clears to 0.
  - Result: aux waits at most STARVE_MAX cycles under continuous CPU load.
- Read return:
  - A granted read (we=0) in cycle N sets that requester's rvalid in cycle N+1 for exactly one cycle.
  - A granted write sets no rvalid.
  - During the rvalid cycle, rdata = mem_dout (pass-through).
  - At the end of the rvalid cycle, mem_dout is captured into a hold register; rdata shows the hold value in all other cycles.
  - Back-to-back reads by one requester produce rvalid on consecutive cycles, each carrying its own data.
- owner: registered at each edge to the grant of that cycle (00 if none).
- Requester contract:
  - A requester may drop req only after its grant.
  - Changing addr/we while req is high and ungranted is undefined.
  - Write-then-read to the same address from different requesters is ordered by grant order; read returns the newly written value.
- Simultaneous events:
  - Both request with starve_cnt < STARVE_MAX: CPU wins.
  - At STARVE_MAX: aux wins and the CPU stalls one cycle.
  - A grant and an rvalid for the same requester in the same cycle are legal (pipelined reads).

Test Plan:
- Reset: hold reset=0 with cpu_req=1 -> all grants, rvalids, mem_we = 0, owner=00; after release, cpu_grant=1 the same cycle.
- CPU read: RAM[0x005]=0xBEEF, cpu_req=1, we=0, addr=0x005 -> cpu_grant=1 in cycle N, cpu_rvalid=1 with cpu_rdata=0xBEEF in N+1, rdata holds 0xBEEF after.
- Write/read: cpu write 0x1234 to 0x3FF, then aux read of 0x3FF -> aux_rvalid one cycle after aux_grant with aux_rdata=0x1234; mem_addr=0x3FF wraps at no other value.
- Contention: both req continuously, STARVE_MAX=4 -> CPU granted 4 cycles, aux granted the 5th, pattern repeats; starve_cnt never exceeds 4.
- Idle aux: aux_req=0, cpu_req=1 for 20 cycles -> cpu_grant=1 every cycle, starve_cnt=0, owner=01.
- Reset mid-read: cpu read granted, reset=0 asserted before the next edge -> no cpu_rvalid pulse, cpu_rdata=0.
